// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: req/ack handshake to data memory with byte/half/word lane formatting.
// Optional build macro LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses and add the misalign output.
module lsu_mem_stage #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  rd_out,
  output logic        we_out,
  output logic [31:0] rdata_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       f3_q, f3_d;
  logic [4:0]       rd_q, rd_d;
  logic             load_q, load_d;
  logic             err_q, err_d;
  logic             we_q, we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d;

  logic        accept, timeout, size_b, size_h, mis_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, lane, fmt;
  logic [4:0]  shamt;

  assign accept  = (state_q == S_IDLE) && valid && (is_load ^ is_store);
  assign timeout = (MAX_WAIT != 0) && (cnt_q == CNT_W'(MAX_WAIT - 1));

  // funct3[1:0] alone selects the size, so 011/110/111 all fall through to word
  assign size_b = (f3_q[1:0] == 2'b00);
  assign size_h = (f3_q[1:0] == 2'b01);

  always_comb begin
    if (load_q)      be_c = 4'b1111;
    else if (size_b) be_c = 4'b0001 << addr_q[1:0];
    else if (size_h) be_c = addr_q[1] ? 4'b1100 : 4'b0011;
    else             be_c = 4'b1111;
  end

  assign wdata_c = size_b ? {4{wdata_q[7:0]}} : size_h ? {2{wdata_q[15:0]}} : wdata_q;
  assign shamt   = size_b ? {addr_q[1:0], 3'b000} : size_h ? {addr_q[1], 4'b0000} : 5'd0;
  assign lane    = mem_rdata >> shamt;
  assign fmt     = size_b ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]}
                 : size_h ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]}
                 : lane;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] != 2'b00) && (funct3[1:0] != 2'b01) && (addr[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    load_d  = load_q;
    err_d   = err_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = addr;
          wdata_d = wdata;
          f3_d    = funct3;
          rd_d    = rd;
          load_d  = is_load;
          cnt_d   = '0;
          we_d    = 1'b0;
          rdata_d = '0;
          mis_d   = mis_c;
          err_d   = mis_c;
          state_d = mis_c ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (load_q) begin
            rdata_d = fmt;
            we_d    = (rd_q != 5'd0);
          end
        end else if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
      err_q   <= err_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Memory-side outputs are gated so they read 0 outside REQ
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done & err_q;
  assign we_out    = done & we_q;
  assign rdata_out = done ? rdata_q : 32'd0;
  assign rd_out    = rd_q;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req & ~load_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = mem_req ? be_c : 4'd0;
  assign mem_wdata = (mem_req & ~load_q) ? wdata_c : 32'd0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = done & mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q ^ mis_c;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: random load/store traffic against a byte-level reference model.
module tb_lsu_mem_stage;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, err, we_out, mem_req, mem_we;
  logic [4:0]  rd_out;
  logic [31:0] rdata_out, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  lsu_mem_stage #(.MAX_WAIT(MW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rd(rd),
    .busy(busy), .done(done), .err(err), .rd_out(rd_out), .we_out(we_out),
    .rdata_out(rdata_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic        err;
    logic        mis;
    logic [31:0] rdata;
    int          k;
    int          acc;
  } res_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          d;
    logic [31:0] rdata;
    int          k;
  } mreq_t;

  res_t  sq[$];
  mreq_t mq[$];

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3,
                                           input logic [31:0] word);
    logic [7:0]  b [4];
    logic [31:0] v;
    int          base;
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    case (size_of(f3))
      1: begin
        v = {24'd0, b[int'(a[1:0])]};
        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end
      2: begin
        base = a[1] ? 2 : 0;
        v = {16'd0, b[base+1], b[base]};
        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w, input logic [4:0] r,
                       input int d, input logic [31:0] word);
    res_t  e;
    mreq_t m;
    int    sz;
    logic  mis, errx, acc, seen;
    sz  = size_of(f3);
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((sz == 2) && a[0]) || ((sz == 4) && (a[1:0] != 2'b00));
`endif
    errx = mis || (d >= MW);
    valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = w; rd = r;
    if (!(ld ^ st)) begin
      repeat (2) begin
        @(posedge clk); #1;
        chk("ignored_busy", busy, 0);
      end
      valid = 1'b0;
      return;
    end
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (busy) begin acc = 1'b1; break; end
    end
    valid = 1'b0;
    if (!acc) begin
      chk("accept", busy, 1);
      return;
    end
    e.rd    = r;
    e.err   = errx;
    e.we    = ld && (r != 5'd0) && !errx;
    e.mis   = mis;
    e.rdata = (ld && !errx) ? load_val(a, f3, word) : 32'd0;
    e.k     = mis ? 0 : ((d < MW) ? d + 1 : MW);
    e.acc   = cyc;
    sq.push_back(e);
    if (!mis) begin
      m.we    = st;
      m.addr  = a & 32'hFFFF_FFFC;
      m.be    = ld ? 4'hF : (sz == 1) ? 4'(1 << int'(a[1:0])) : (sz == 2) ? (a[1] ? 4'hC : 4'h3) : 4'hF;
      m.wdata = (sz == 1) ? w[7:0] * 32'h0101_0101 : (sz == 2) ? w[15:0] * 32'h0001_0001 : w;
      m.d     = d;
      m.rdata = word;
      m.k     = e.k;
      mq.push_back(m);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen) chk("done_timeout", done, 1);
  endtask

  // Result monitor
  initial begin
    res_t e;
    logic chk_next;
    chk_next = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk_next = 1'b0;
      end else if (done) begin
        if (sq.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e = sq.pop_front();
          chk("err", err, e.err);
          chk("we_out", we_out, e.we);
          chk("rd_out", rd_out, e.rd);
          chk("rdata_out", rdata_out, e.rdata);
          chk("done_cycle", cyc, e.acc + e.k);
`ifdef LSU_MISALIGN_TRAP_EN
          chk("misalign", misalign, e.mis);
`endif
        end
        chk_next = 1'b1;
      end else if (chk_next) begin
        chk("done_to_idle", busy, 0);
        chk_next = 1'b0;
      end
    end
  end

  // Memory responder and request-side checker
  initial begin
    mreq_t cur;
    logic  active;
    int    n;
    active = 1'b0; n = 0;
    cur.d = 99; cur.k = -1; cur.we = 0; cur.addr = 0; cur.be = 0; cur.wdata = 0; cur.rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0; n = 0; mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1'b1; n = 0;
          if (mq.size() == 0) begin
            chk("unexpected_req", mem_req, 0);
            cur.d = 99; cur.k = -1;
          end else begin
            cur = mq.pop_front();
          end
        end
        chk("mem_we", mem_we, cur.we);
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_be", mem_be, cur.be);
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        mem_ack   = (n == cur.d);
        mem_rdata = mem_ack ? cur.rdata : $urandom;
        n++;
      end else begin
        if (active) begin
          chk("req_cycles", n, cur.k);
          active = 1'b0;
        end
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  initial begin
    int r;
    logic ld, st;
    logic [2:0] f3;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_we_out", we_out, 0);
    chk("rst_rdata_out", rdata_out, 0);
    chk("rst_rd_out", rd_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1, 0, 3'b000, 32'h1003, 0, 5'd1, 0, 32'h80FF_1234);
    issue(1, 0, 3'b101, 32'h2002, 0, 5'd3, 0, 32'hBEEF_0000);
    issue(1, 0, 3'b001, 32'h2002, 0, 5'd3, 0, 32'hBEEF_0000);
    issue(0, 1, 3'b000, 32'h3001, 32'h0000_00AB, 5'd4, 0, 0);
    issue(0, 1, 3'b010, 32'h3004, 32'h1234_5678, 5'd4, 0, 0);
    issue(1, 0, 3'b010, 32'h4000, 0, 5'd7, 9, 32'h1);
    issue(0, 1, 3'b001, 32'h4002, 32'h0000_BEEF, 5'd7, 9, 0);
    issue(1, 0, 3'b010, 32'h4000, 0, 5'd7, 3, 32'hCAFE_F00D);
    issue(1, 0, 3'b010, 32'h5000, 0, 5'd0, 0, 32'h55);
    issue(1, 0, 3'b010, 32'h1002, 0, 5'd9, 0, 32'hDEAD_BEEF);
    issue(1, 0, 3'b001, 32'h1001, 0, 5'd9, 1, 32'h8001_7F02);
    issue(1, 1, 3'b010, 32'h6000, 0, 5'd2, 0, 0);
    issue(0, 0, 3'b010, 32'h6000, 0, 5'd2, 0, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      ld = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : r[0];
      st = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : ~r[0];
      f3 = (st && !ld) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      issue(ld, st, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 5), $urandom);
    end

    // Reset in the middle of an outstanding request
    @(posedge clk); #1;
    valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h7000; rd = 5'd5;
    mq.push_back('{we: 1'b0, addr: 32'h7000, be: 4'hF, wdata: 32'd0, d: 99, rdata: 32'd0, k: MW});
    @(posedge clk); #1;
    valid = 1'b0;
    chk("rst_mid_busy_before", busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    mq.delete();
    sq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);
    issue(0, 1, 3'b000, 32'h3002, 32'h0000_0011, 5'd2, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sq_drain", sq.size(), 0);
    chk("mq_drain", mq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
